conv_mac_sched: RTL and testbench

Convolution sequencer for the LeNet co-processor's single MAC unit. On `start` it walks every output pixel of one feature map. For each pixel it walks all K×K kernel taps, drives read addresses to the image and weight buffers, and generates the MAC's `en`/`first_data`/`last_data` strobes aligned with the buffer read data. It also emits an output-write strobe and address aligned with the MAC's `q_en`, so the result writer needs no extra bookkeeping.

---
 rtl/conv_mac_sched.sv | 177 +++++++++++++++++
 tb/tb_conv_mac_sched.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_sched.sv
// rtl/conv_mac_sched.sv - convolution tap sequencer for a single MAC unit
//
// Walks every output pixel (ox,oy) of one feature map and, for each, every
// kernel tap (kx,ky), issuing one image/weight buffer read per cycle.
// MAC strobes follow the issue by one cycle (buffer read latency) and the
// result-write strobe follows mac_last by one more cycle.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                one-cycle launch pulse, ignored while busy
//   pause                stall request, honoured only at window boundaries
//   busy, done           sequence in progress / final-result pulse
//   img_rd               buffer read strobe (issue stage)
//   img_addr, wgt_addr   image and weight read addresses
//   mac_en/first/last    MAC strobes, one cycle after issue
//   out_vld, out_addr    result-write strobe and output address
//   perf_cyc             busy-cycle counter (only with CONV_SCHED_PERF_EN)
//
// Optional feature macro: CONV_SCHED_PERF_EN
module conv_mac_sched #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    parameter int K     = 5,
    parameter int IA_W  = 10,
    parameter int WA_W  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            pause,
    output logic            busy,
    output logic            done,
    output logic            img_rd,
    output logic [IA_W-1:0] img_addr,
    output logic [WA_W-1:0] wgt_addr,
    output logic            mac_en,
    output logic            mac_first,
    output logic            mac_last,
    output logic            out_vld,
    output logic [IA_W-1:0] out_addr
`ifdef CONV_SCHED_PERF_EN
    ,
    output logic [31:0]     perf_cyc
`endif
);

    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;
    localparam int XW    = $clog2(OUT_W + 1);
    localparam int YW    = $clog2(OUT_H + 1);
    localparam int KW    = $clog2(K + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   kx_q, kx_d, ky_q, ky_d;
    logic [XW-1:0]   ox_q, ox_d;
    logic [YW-1:0]   oy_q, oy_d;

    logic            mac_en_q, mac_first_q, mac_last_q, final_q;
    logic [IA_W-1:0] oaddr_s1_q;
    logic            out_vld_q, done_q;
    logic [IA_W-1:0] out_addr_q;

    logic first_tap, last_tap, last_win, hold, issue;

    always_comb begin
        first_tap = (kx_q == '0) && (ky_q == '0);
        last_tap  = (kx_q == KW'(K - 1)) && (ky_q == KW'(K - 1));
        last_win  = (ox_q == XW'(OUT_W - 1)) && (oy_q == YW'(OUT_H - 1));
        // Pause only bites at tap (0,0) of a window other than the first,
        // so a window's taps are never split across a stall.
        hold      = (state_q == S_RUN) && first_tap &&
                    ((ox_q != '0) || (oy_q != '0)) && pause;
        issue     = (state_q == S_RUN) && !hold;
    end

    always_comb begin
        state_d = state_q;
        kx_d    = kx_q;
        ky_d    = ky_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    kx_d    = '0;
                    ky_d    = '0;
                    ox_d    = '0;
                    oy_d    = '0;
                end
            end
            S_RUN: begin
                if (issue) begin
                    if (last_tap) begin
                        kx_d = '0;
                        ky_d = '0;
                        if (ox_q == XW'(OUT_W - 1)) begin
                            ox_d = '0;
                            oy_d = (oy_q == YW'(OUT_H - 1)) ? '0 : oy_q + YW'(1);
                        end else begin
                            ox_d = ox_q + XW'(1);
                        end
                        if (last_win) state_d = S_DRAIN;
                    end else if (kx_q == KW'(K - 1)) begin
                        kx_d = '0;
                        ky_d = ky_q + KW'(1);
                    end else begin
                        kx_d = kx_q + KW'(1);
                    end
                end
            end
            S_DRAIN: begin
                // Leave once the final result has been written.
                if (done_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            kx_q        <= '0;
            ky_q        <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            mac_en_q    <= 1'b0;
            mac_first_q <= 1'b0;
            mac_last_q  <= 1'b0;
            final_q     <= 1'b0;
            oaddr_s1_q  <= '0;
            out_vld_q   <= 1'b0;
            done_q      <= 1'b0;
            out_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            kx_q        <= kx_d;
            ky_q        <= ky_d;
            ox_q        <= ox_d;
            oy_q        <= oy_d;
            mac_en_q    <= issue;
            mac_first_q <= issue && first_tap;
            mac_last_q  <= issue && last_tap;
            final_q     <= issue && last_tap && last_win;
            if (issue && last_tap)
                oaddr_s1_q <= IA_W'(32'(oy_q) * 32'(OUT_W) + 32'(ox_q));
            out_vld_q   <= mac_last_q;
            done_q      <= mac_last_q && final_q;
            if (mac_last_q)
                out_addr_q <= oaddr_s1_q;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign img_rd    = issue;
    assign img_addr  = IA_W'((32'(oy_q) + 32'(ky_q)) * 32'(IMG_W) + 32'(ox_q) + 32'(kx_q));
    assign wgt_addr  = WA_W'(32'(ky_q) * 32'(K) + 32'(kx_q));
    assign mac_en    = mac_en_q;
    assign mac_first = mac_first_q;
    assign mac_last  = mac_last_q;
    assign out_vld   = out_vld_q;
    assign out_addr  = out_addr_q;

`ifdef CONV_SCHED_PERF_EN
    logic [31:0] perf_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           perf_q <= '0;
        else if (state_q == S_IDLE && start)  perf_q <= '0;
        else if (busy)                        perf_q <= perf_q + 32'd1;
    end
    assign perf_cyc = perf_q;
`endif

endmodule

// File: tb/tb_conv_mac_sched.sv
// tb/tb_conv_mac_sched.sv - self-checking bench for conv_mac_sched
module tb_conv_mac_sched;
    localparam int IMG_W = 4, IMG_H = 4, K = 3, IA_W = 10, WA_W = 5;
    localparam int OUT_W = IMG_W - K + 1, OUT_H = IMG_H - K + 1;
    localparam int NW = OUT_W * OUT_H, TAPS = K * K, MAXC = 256;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, pause = 1'b0;
    logic busy, done, img_rd, mac_en, mac_first, mac_last, out_vld;
    logic [IA_W-1:0] img_addr, out_addr;
    logic [WA_W-1:0] wgt_addr;
`ifdef CONV_SCHED_PERF_EN
    logic [31:0] perf_cyc;
`endif

    int total = 0, bad = 0;
    bit pz[MAXC];
    bit st[MAXC];
    bit e_rd[MAXC], e_en[MAXC], e_first[MAXC], e_last[MAXC], e_vld[MAXC], e_done[MAXC], e_busy[MAXC];
    int e_ia[MAXC], e_wa[MAXC], e_oa[MAXC], e_oa_at[MAXC];
    int oa_hold = 0;
    int done_c;
    int obs_done_c;

    conv_mac_sched #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .IA_W(IA_W), .WA_W(WA_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause),
        .busy(busy), .done(done), .img_rd(img_rd),
        .img_addr(img_addr), .wgt_addr(wgt_addr),
        .mac_en(mac_en), .mac_first(mac_first), .mac_last(mac_last),
        .out_vld(out_vld), .out_addr(out_addr)
`ifdef CONV_SCHED_PERF_EN
        , .perf_cyc(perf_cyc)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 0, busy, 0);
        chk({tag, "_done"}, 0, done, 0);
        chk({tag, "_img_rd"}, 0, img_rd, 0);
        chk({tag, "_img_addr"}, 0, img_addr, 0);
        chk({tag, "_wgt_addr"}, 0, wgt_addr, 0);
        chk({tag, "_mac_en"}, 0, mac_en, 0);
        chk({tag, "_mac_first"}, 0, mac_first, 0);
        chk({tag, "_mac_last"}, 0, mac_last, 0);
        chk({tag, "_out_vld"}, 0, out_vld, 0);
        chk({tag, "_out_addr"}, 0, out_addr, 0);
    endtask

    // Expected timeline: windows in raster order, taps in raster order,
    // one tap per cycle from cycle 1; paused cycles only delay window starts.
    task automatic build_model();
        int c;
        for (int i = 0; i < MAXC; i++) begin
            e_rd[i] = 0; e_en[i] = 0; e_first[i] = 0; e_last[i] = 0;
            e_vld[i] = 0; e_done[i] = 0; e_busy[i] = 0;
            e_ia[i] = 0; e_wa[i] = 0; e_oa[i] = 0; e_oa_at[i] = 0;
        end
        c = 1;
        for (int w = 0; w < NW; w++) begin
            if (w > 0) while (pz[c]) c++;
            for (int t = 0; t < TAPS; t++) begin
                e_rd[c] = 1;
                e_ia[c] = ((w / OUT_W) + t / K) * IMG_W + (w % OUT_W) + t % K;
                e_wa[c] = t;
                e_en[c + 1] = 1;
                e_first[c + 1] = (t == 0);
                e_last[c + 1] = (t == TAPS - 1);
                if (t == TAPS - 1) begin
                    e_vld[c + 2] = 1;
                    e_oa_at[c + 2] = w;
                end
                c++;
            end
        end
        done_c = c + 1;
        e_done[done_c] = 1;
        for (int i = 1; i <= done_c; i++) e_busy[i] = 1;
        for (int i = 1; i < MAXC; i++) begin
            if (e_vld[i]) oa_hold = e_oa_at[i];
            e_oa[i] = oa_hold;
        end
    endtask

    task automatic run(input int abort_c);
        build_model();
        obs_done_c = -1;
        start = 1'b1;
        pause = 1'b0;
        for (int c = 1; c <= done_c + 2; c++) begin
            @(posedge clk); #1;
            start = st[c];
            pause = pz[c];
            if (c == abort_c) begin
                rst_n = 1'b0;
                #1;
                chk_zero("abort");
                oa_hold = 0;
                start = 1'b0;
                pause = 1'b0;
                return;
            end
            @(negedge clk);
            if (done === 1'b1) obs_done_c = c;
            chk("busy", c, busy, e_busy[c]);
            chk("done", c, done, e_done[c]);
            chk("img_rd", c, img_rd, e_rd[c]);
            if (e_rd[c]) begin
                chk("img_addr", c, img_addr, e_ia[c]);
                chk("wgt_addr", c, wgt_addr, e_wa[c]);
            end
            chk("mac_en", c, mac_en, e_en[c]);
            chk("mac_first", c, mac_first, e_first[c]);
            chk("mac_last", c, mac_last, e_last[c]);
            chk("out_vld", c, out_vld, e_vld[c]);
            chk("out_addr", c, out_addr, e_oa[c]);
        end
`ifdef CONV_SCHED_PERF_EN
        chk("perf_cyc", done_c + 2, perf_cyc, done_c);
`endif
        start = 1'b0;
        pause = 1'b0;
    endtask

    task automatic clear_stim();
        for (int i = 0; i < MAXC; i++) begin
            pz[i] = 0;
            st[i] = 0;
        end
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // full run, start re-pulsed mid-run and coincident with done
        clear_stim();
        st[20] = 1;
        st[38] = 1;
        run(0);
        chk("done_cycle_nopause", 0, obs_done_c, 38);

        // pause across the window-1 boundary
        clear_stim();
        pz[10] = 1; pz[11] = 1; pz[12] = 1;
        run(0);
        chk("done_cycle_pause3", 0, obs_done_c, 41);

        // mid-window pause ignored
        clear_stim();
        pz[5] = 1;
        run(0);
        chk("done_cycle_midpause", 0, obs_done_c, 38);

        // reset mid-sequence, then a clean run
        clear_stim();
        run(15);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("post_reset");
        @(posedge clk); #1;
        clear_stim();
        run(0);
        chk("done_cycle_after_reset", 0, obs_done_c, 38);

        // randomized pause patterns
        for (int r = 0; r < 6; r++) begin
            clear_stim();
            for (int i = 1; i < 80; i++) pz[i] = ($urandom_range(0, 3) == 0);
            run(0);
            chk("done_cycle_rand", r, obs_done_c, done_c);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
